countdown_timer_dp: RTL

Countdown datapath: the down-counting counterpart of the stopwatch datapath. Loads an hour/min/sec/centisecond value, decrements it at 100 Hz while run is asserted, and flags expiry with a one-cycle `o_done` pulse. Sits beside the stopwatch datapath under the same control unit and drives the same display fields.

---
 rtl/countdown_timer_dp_pkg.sv | 22 ++
 rtl/countdown_timer_dp_tick.sv | 31 +++
 rtl/countdown_timer_dp.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/countdown_timer_dp_pkg.sv
// Shared types and field limits for the countdown datapath.
package countdown_timer_dp_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ARMED,
        ST_RUN,
        ST_PAUSE,
        ST_DONE
    } cd_state_e;

    localparam int HOUR_W = 5;
    localparam int MIN_W  = 6;
    localparam int SEC_W  = 6;
    localparam int MSEC_W = 7;

    localparam logic [HOUR_W-1:0] HOUR_MAX = 5'd23;
    localparam logic [MIN_W-1:0]  MIN_MAX  = 6'd59;
    localparam logic [SEC_W-1:0]  SEC_MAX  = 6'd59;
    localparam logic [MSEC_W-1:0] MSEC_MAX = 7'd99;

endpackage

// File: rtl/countdown_timer_dp_tick.sv
// cd_tick_gen: free prescaler counting 0..FCOUNT-1 while enabled; wrap_o flags the last count.
module cd_tick_gen #(
    parameter int FCOUNT = 10
) (
    input  logic clk,
    input  logic rst,
    input  logic en_i,
    input  logic clr_i,
    output logic wrap_o
);
    localparam int CW = (FCOUNT > 1) ? $clog2(FCOUNT) : 1;
    localparam logic [CW-1:0] LAST = CW'(FCOUNT - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    assign wrap_o = en_i && (cnt_q == LAST);

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i)
            cnt_d = '0;
        else if (en_i)
            cnt_d = (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end

endmodule

// File: rtl/countdown_timer_dp.sv
// Countdown datapath: loads h:m:s:cs, decrements at TICK_HZ while running, pulses o_done at expiry.
// Optional COUNTDOWN_AUTORELOAD_EN: expiry reloads the stored value and keeps running.
module countdown_timer_dp
    import countdown_timer_dp_pkg::*;
#(
    parameter int FREQ_HZ = 100_000_000,
    parameter int TICK_HZ = 100
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_load,
    input  logic [HOUR_W-1:0] i_hour,
    input  logic [MIN_W-1:0]  i_min,
    input  logic [SEC_W-1:0]  i_sec,
    input  logic [MSEC_W-1:0] i_msec,
    input  logic              i_runstop,
    input  logic              i_clear,
    output logic [HOUR_W-1:0] hour,
    output logic [MIN_W-1:0]  min,
    output logic [SEC_W-1:0]  sec,
    output logic [MSEC_W-1:0] msec,
    output logic              o_running,
    output logic              o_done
);
    localparam int FCOUNT = FREQ_HZ / TICK_HZ;

    cd_state_e state_q, state_d;
    logic [HOUR_W-1:0] hour_q, hour_d, rhour_q, rhour_d;
    logic [MIN_W-1:0]  min_q,  min_d,  rmin_q,  rmin_d;
    logic [SEC_W-1:0]  sec_q,  sec_d,  rsec_q,  rsec_d;
    logic [MSEC_W-1:0] msec_q, msec_d, rmsec_q, rmsec_d;
    logic running_q, running_d, done_q, done_d;

    logic load_acc, tick;
    logic [HOUR_W-1:0] ld_hour, dec_hour;
    logic [MIN_W-1:0]  ld_min,  dec_min;
    logic [SEC_W-1:0]  ld_sec,  dec_sec;
    logic [MSEC_W-1:0] ld_msec, dec_msec;
    logic ld_nz, dec_zero, rld_nz;

    assign load_acc = i_load && (state_q != ST_RUN);

    cd_tick_gen #(.FCOUNT(FCOUNT)) u_tick (
        .clk    (clk),
        .rst    (rst),
        .en_i   (state_q == ST_RUN),
        .clr_i  (i_clear || load_acc),
        .wrap_o (tick)
    );

    assign ld_hour = (i_hour > HOUR_MAX) ? HOUR_MAX : i_hour;
    assign ld_min  = (i_min  > MIN_MAX)  ? MIN_MAX  : i_min;
    assign ld_sec  = (i_sec  > SEC_MAX)  ? SEC_MAX  : i_sec;
    assign ld_msec = (i_msec > MSEC_MAX) ? MSEC_MAX : i_msec;
    assign ld_nz   = |{ld_hour, ld_min, ld_sec, ld_msec};
    assign rld_nz  = |{rhour_q, rmin_q, rsec_q, rmsec_q};

    // Borrow chain; only evaluated in RUN, where the value is never zero.
    always_comb begin
        dec_hour = hour_q;
        dec_min  = min_q;
        dec_sec  = sec_q;
        dec_msec = msec_q - 1'b1;
        if (msec_q == '0) begin
            dec_msec = MSEC_MAX;
            dec_sec  = sec_q - 1'b1;
            if (sec_q == '0) begin
                dec_sec = SEC_MAX;
                dec_min = min_q - 1'b1;
                if (min_q == '0) begin
                    dec_min  = MIN_MAX;
                    dec_hour = hour_q - 1'b1;
                end
            end
        end
    end

    assign dec_zero = ~|{dec_hour, dec_min, dec_sec, dec_msec};

    always_comb begin
        state_d = state_q;
        hour_d  = hour_q;
        min_d   = min_q;
        sec_d   = sec_q;
        msec_d  = msec_q;
        rhour_d = rhour_q;
        rmin_d  = rmin_q;
        rsec_d  = rsec_q;
        rmsec_d = rmsec_q;
        done_d  = 1'b0;
        if (i_clear) begin
            state_d = ST_IDLE;
            {hour_d, min_d, sec_d, msec_d}     = '0;
            {rhour_d, rmin_d, rsec_d, rmsec_d} = '0;
        end else if (load_acc) begin
            {hour_d, min_d, sec_d, msec_d}     = {ld_hour, ld_min, ld_sec, ld_msec};
            {rhour_d, rmin_d, rsec_d, rmsec_d} = {ld_hour, ld_min, ld_sec, ld_msec};
            state_d = ld_nz ? ST_ARMED : ST_IDLE;
        end else begin
            case (state_q)
                ST_ARMED, ST_PAUSE: if (i_runstop) state_d = ST_RUN;
                ST_RUN: begin
                    if (tick) begin
                        {hour_d, min_d, sec_d, msec_d} = {dec_hour, dec_min, dec_sec, dec_msec};
                        if (dec_zero) begin
                            done_d = 1'b1;
`ifdef COUNTDOWN_AUTORELOAD_EN
                            if (rld_nz)
                                {hour_d, min_d, sec_d, msec_d} = {rhour_q, rmin_q, rsec_q, rmsec_q};
                            else
                                state_d = ST_DONE;
`else
                            state_d = ST_DONE;
`endif
                        end
                    end
                    if (state_d == ST_RUN && !i_runstop) state_d = ST_PAUSE;
                end
                default: ;
            endcase
        end
    end

    assign running_d = (state_d == ST_RUN);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            hour_q    <= '0;
            min_q     <= '0;
            sec_q     <= '0;
            msec_q    <= '0;
            rhour_q   <= '0;
            rmin_q    <= '0;
            rsec_q    <= '0;
            rmsec_q   <= '0;
            running_q <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            hour_q    <= hour_d;
            min_q     <= min_d;
            sec_q     <= sec_d;
            msec_q    <= msec_d;
            rhour_q   <= rhour_d;
            rmin_q    <= rmin_d;
            rsec_q    <= rsec_d;
            rmsec_q   <= rmsec_d;
            running_q <= running_d;
            done_q    <= done_d;
        end
    end

    // rld_nz is only consumed by the auto-reload build.
    logic unused_rld;
    assign unused_rld = rld_nz;

    assign hour      = hour_q;
    assign min       = min_q;
    assign sec       = sec_q;
    assign msec      = msec_q;
    assign o_running = running_q;
    assign o_done    = done_q;

endmodule
